mem_responder: RTL and testbench

Multi-cycle memory responder serving the pipelined CPU's two memory initiators: the instruction-fetch port and the data-memory port. It arbitrates between them, holds one transaction in flight, and returns a single-cycle acknowledge after a fixed latency. The CPU stalls on its request until `*_ack`. The block sits below fetch and memory, replacing single-cycle memories, and contains the word-storage array.

---
 rtl/mem_responder_pkg.sv | 23 ++
 rtl/mem_responder_array.sv | 30 +++
 rtl/mem_responder.sv | 156 +++++++++++++++
 tb/tb_mem_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM encoding, port
// identifiers and the legal latency range.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // Which initiator owns the in-flight transaction.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    function automatic bit latency_ok(input int lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Single-port synchronous word RAM with a registered read port.
module mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     re,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write on we, capture the addressed word into the read register on re.
    // NOTE: storage and its read register have no reset; contents must survive a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder: arbitrates the instruction and data ports
// (data wins), keeps one transaction in flight and acknowledges it with a
// single-cycle pulse exactly LATENCY cycles after acceptance.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              busy
);

    localparam int               IDX_W    = $clog2(MEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    if (!latency_ok(LATENCY)) begin : g_latency_range
        $error("mem_responder: LATENCY must be in 1..15");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               port_q, port_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  i_rdata_q, d_rdata_q;
    logic [DATA_W-1:0]  arr_rdata;
    logic               arr_re, arr_we;

    // Bit 0 (byte within word) and bits above the array index are dropped,
    // which is what makes addresses wrap modulo MEM_WORDS.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[0], d_addr[0],
                                i_addr[ADDR_W-1:IDX_W+1], d_addr[ADDR_W-1:IDX_W+1]};

    // Next-state logic: arbitration and latching in IDLE, countdown in WAIT.
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (d_req) begin
                    port_d  = PORT_D;
                    idx_d   = d_addr[IDX_W:1];
                    we_d    = d_we;
                    wdata_d = d_wdata;
                end else if (i_req) begin
                    port_d  = PORT_I;
                    idx_d   = i_addr[IDX_W:1];
                    we_d    = 1'b0;
                end
                if (d_req || i_req) begin
                    if (LATENCY == 1) begin
                        state_d = ST_ACK;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and latched-request registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            port_q  <= PORT_I;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            port_q  <= port_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // The read is launched on the edge entering ACK so the registered word is
    // on arr_rdata during the ack cycle. idx_d equals the latched index both
    // then and in ACK itself, so one index bus serves reads and writes.
    // A store is committed on the ACK edge unless reset wins that edge.
    assign arr_re = (state_d == ST_ACK) && !we_d;
    assign arr_we = (state_q == ST_ACK) && we_q && !rst;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_WORDS)
    ) u_array (
        .clk   (clk),
        .re    (arr_re),
        .we    (arr_we),
        .idx   (idx_d),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign i_ack = (state_q == ST_ACK) && (port_q == PORT_I);
    assign d_ack = (state_q == ST_ACK) && (port_q == PORT_D);
    assign busy  = (state_q != ST_IDLE);

    // Hold each port's last read word until that port's next load ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (i_ack) begin
                i_rdata_q <= arr_rdata;
            end
            if (d_ack && !we_q) begin
                d_rdata_q <= arr_rdata;
            end
        end
    end

    assign i_rdata = i_ack ? arr_rdata : i_rdata_q;
    assign d_rdata = (d_ack && !we_q) ? arr_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance at LATENCY=4 and one at
// LATENCY=1. Stimulus pushes expected (cycle, rdata) per port; a negedge
// monitor pops and compares whenever an ack appears.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // LATENCY=4 instance
    logic        i_req, i_ack, d_req, d_we, d_ack, busy;
    logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    // LATENCY=1 instance
    logic        i1_req, i1_ack, d1_req, d1_we, d1_ack, busy1;
    logic [15:0] i1_addr, i1_rdata, d1_addr, d1_wdata, d1_rdata;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    // 0: d (lat4), 1: i (lat4), 2: d (lat1), 3: i (lat1)
    exp_t q[4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(1024), .LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy)
    );

    mem_responder #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i1_req), .i_addr(i1_addr), .i_ack(i1_ack), .i_rdata(i1_rdata),
        .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
        .d_ack(d1_ack), .d_rdata(d1_rdata), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic score(input int w, input string name, input logic [15:0] rd);
        exp_t e;
        check({name, " ack expected"}, 32'(q[w].size() != 0), 32'd1);
        if (q[w].size() != 0) begin
            e = q[w].pop_front();
            check({name, " ack cycle"}, cyc, e.cyc);
            check({name, " rdata"}, {16'h0, rd}, {16'h0, e.data});
        end
    endtask

    // Monitor: every ack observed must match the head of its port's queue.
    always @(negedge clk) begin
        if (d_ack)  score(0, "d4", d_rdata);
        if (i_ack)  score(1, "i4", i_rdata);
        if (d1_ack) score(2, "d1", d1_rdata);
        if (i1_ack) score(3, "i1", i1_rdata);
    end

    task automatic wait_ack(input int w);
        bit seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            case (w)
                0:       seen = d_ack;
                1:       seen = i_ack;
                2:       seen = d1_ack;
                default: seen = i1_ack;
            endcase
        end
        if (!seen) check($sformatf("ack timeout port %0d", w), 32'(seen), 32'd1);
    endtask

    // Data-port operation on the LATENCY=4 instance; lat is the hand-computed
    // offset from the issue cycle to the expected ack.
    task automatic d_op(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int lat, input logic [15:0] exp_rd);
        q[0].push_back('{cyc + lat, exp_rd});
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_req   = 1'b1;
        wait_ack(0);
        @(posedge clk); #1;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic i_op(input logic [15:0] addr, input int lat, input logic [15:0] exp_rd);
        q[1].push_back('{cyc + lat, exp_rd});
        i_addr = addr;
        i_req  = 1'b1;
        wait_ack(1);
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] words [4];
        int          base;
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;

        rst = 1'b1;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        i1_req = 1'b0; i1_addr = '0; d1_req = 1'b0; d1_we = 1'b0; d1_addr = '0; d1_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: nothing moves.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle busy/acks", {28'h0, busy, i_ack, d_ack, busy1}, 32'h0);
            check("idle rdata", {i_rdata, d_rdata}, 32'h0);
        end
        @(posedge clk); #1;

        // Preload word 0, then store/load round trip (store keeps d_rdata).
        d_op(1'b1, 16'h0000, 16'hA5A5, 4, 16'h0000);
        d_op(1'b1, 16'h0010, 16'hBEEF, 4, 16'h0000);
        d_op(1'b0, 16'h0011, 16'h0000, 4, 16'hBEEF);

        // Simultaneous requests: D acked at +4, I accepted at +5, acked at +9.
        fork
            d_op(1'b0, 16'h0010, 16'h0000, 4, 16'hBEEF);
            i_op(16'h0000, 9, 16'hA5A5);
        join

        // Wrap: 2*MEM_WORDS+4 aliases byte address 4.
        d_op(1'b1, 16'h0804, 16'h1234, 4, 16'hBEEF);
        d_op(1'b0, 16'h0004, 16'h0000, 4, 16'h1234);

        // Store aborted by reset two cycles after issue: no ack, no write.
        d_we = 1'b1; d_addr = 16'h0004; d_wdata = 16'hDEAD; d_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("busy after reset", {31'h0, busy}, 32'h0);
        check("d_rdata after reset", {16'h0, d_rdata}, 32'h0);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        d_op(1'b0, 16'h0004, 16'h0000, 4, 16'h1234);

        // LATENCY=1: stores back to back, then a continuous fetch stream
        // acked every second cycle.
        base = cyc;
        for (int k = 0; k < 4; k++) begin
            q[2].push_back('{base + 1 + 2 * k, 16'h0000});
            d1_we = 1'b1; d1_addr = 16'h0020 + 16'(2 * k); d1_wdata = words[k]; d1_req = 1'b1;
            wait_ack(2);
            @(posedge clk); #1;
        end
        d1_req = 1'b0; d1_we = 1'b0;
        base = cyc;
        for (int k = 0; k < 4; k++) begin
            q[3].push_back('{base + 1 + 2 * k, words[k]});
            i1_addr = 16'h0020 + 16'(2 * k) + 16'(k & 1);
            i1_req  = 1'b1;
            wait_ack(3);
            @(posedge clk); #1;
        end
        i1_req = 1'b0;

        repeat (8) @(negedge clk);
        for (int w = 0; w < 4; w++) begin
            check($sformatf("pending acks port %0d", w), q[w].size(), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
